// File: rtl/regfile_pkg.sv
// Shared defaults and reset-value helper for the multi-port integer register file.
package regfile_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam int          DEF_NREGS    = 32;
    localparam int          DEF_SP_IDX   = 2;
    localparam int          MAX_XLEN     = 64;
    localparam logic [63:0] DEF_SP_RESET = 64'h0000_0000_FFFF_FFFF;

    // Only the stack pointer comes out of reset non-zero.
    function automatic logic [MAX_XLEN-1:0] reset_value(input int k, input int sp_idx,
                                                        input logic [MAX_XLEN-1:0] sp_reset);
        return (k == sp_idx) ? sp_reset : '0;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, plus per-port busy lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_busy
);

    logic [NREGS-1:0] busy;

    // Issue is applied after the clear so a same-edge issue wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (we && wr_addr != '0)
                busy[wr_addr] <= 1'b0;
            if (issue_en && issue_addr != '0)
                busy[issue_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        logic [AW-1:0] ra;
        logic          retiring;
        assign ra       = rs_addr[i*AW +: AW];
        assign retiring = (BYPASS != 0) && we && (wr_addr == ra);
        assign rs_busy[i] = !rst && (ra != '0) && busy[ra] && !retiring;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: hardwired x0, programmable SP reset, optional write bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              NREGS    = DEF_NREGS,
    parameter int              NRD      = 2,
    parameter int              SP_IDX   = DEF_SP_IDX,
    parameter logic [XLEN-1:0] SP_RESET = XLEN'(DEF_SP_RESET),
    parameter int              BYPASS   = 1,
    localparam int             AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr
);

    logic [NREGS-1:0][XLEN-1:0] regs;

    function automatic logic [XLEN-1:0] rst_val(input int k);
        logic [MAX_XLEN-1:0] v;
        v = reset_value(k, SP_IDX, MAX_XLEN'(SP_RESET));
        return v[XLEN-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++)
                regs[k] <= rst_val(k);
        end else if (we && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Outputs present the reset image while rst is held, independent of we.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        assign ra = rs_addr[i*AW +: AW];
        always_comb begin
            rd = regs[ra];
            if (rst)
                rd = rst_val(int'(ra));
            else if (ra == '0)
                rd = '0;
            else if ((BYPASS != 0) && we && (wr_addr == ra))
                rd = wr_data;
        end
        assign rs_data[i*XLEN +: XLEN] = rd;
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rs_addr    (rs_addr),
        .rs_busy    (rs_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and no-bypass instances against an array-based reference model.
module tb_regfile_mp;

    localparam int          XLEN  = 32;
    localparam int          NREGS = 32;
    localparam int          NRD   = 2;
    localparam int          AW    = 5;
    localparam logic [31:0] SPV   = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, we, issue_en;
    logic [AW-1:0]       wr_addr, issue_addr;
    logic [XLEN-1:0]     wr_data;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rd_byp, rd_nob;
    logic [NRD-1:0]      bz_byp, bz_nob;

    int checks = 0;
    int errors = 0;

    logic [31:0] mreg [NREGS];
    bit          mbusy[NREGS];

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .SP_IDX(2), .SP_RESET(SPV), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rd_byp), .rs_busy(bz_byp),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr));

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .SP_IDX(2), .SP_RESET(SPV), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rd_nob), .rs_busy(bz_nob),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr));

    // Expected {busy, data} for a read of address a, straight from the read rules.
    function automatic logic [32:0] exp_rd(input int a, input bit byp);
        if (rst) return {1'b0, (a == 2) ? SPV : 32'h0};
        if (a == 0) return 33'h0;
        if (byp && we && int'(wr_addr) == a) return {1'b0, wr_data};
        return {mbusy[a], mreg[a]};
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                mreg[k]  = (k == 2) ? SPV : 32'h0;
                mbusy[k] = 1'b0;
            end
        end else begin
            if (we && wr_addr != 0) begin
                mreg[wr_addr]  = wr_data;
                mbusy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) mbusy[issue_addr] = 1'b1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; issue_en = 0; wr_addr = 0; issue_addr = 0; wr_data = 0;
    endtask

    task automatic test_reset();
        rst = 1; we = 1; wr_addr = 2; wr_data = 32'h5555_0000; issue_en = 1; issue_addr = 6;
        step();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin rst = 0; idle(); end
            for (int k = 0; k < NREGS; k++) begin
                rs_addr = {AW'((k + 16) % NREGS), AW'(k)};
                #1;
                for (int p = 0; p < NRD; p++) begin
                    int a;
                    a = int'(rs_addr[p*AW +: AW]);
                    checks += 2;
                    if ({bz_byp[p], rd_byp[p*32 +: 32]} !== exp_rd(a, 1)) begin
                        errors++;
                        $display("FAIL reset_byp rst=%0d port%0d addr%0d got %h want %h", rst, p, a,
                                 {bz_byp[p], rd_byp[p*32 +: 32]}, exp_rd(a, 1));
                    end
                    if ({bz_nob[p], rd_nob[p*32 +: 32]} !== exp_rd(a, 0)) begin
                        errors++;
                        $display("FAIL reset_nob rst=%0d port%0d addr%0d got %h want %h", rst, p, a,
                                 {bz_nob[p], rd_nob[p*32 +: 32]}, exp_rd(a, 0));
                    end
                end
            end
        end
        rs_addr = {AW'(0), AW'(2)};
        #1;
        checks++;
        if (rd_byp[31:0] !== 32'hFFFF_FFFF || bz_byp !== 2'b00) begin
            errors++;
            $display("FAIL reset_sp got %h busy %b want ffffffff busy 00", rd_byp[31:0], bz_byp);
        end
    endtask

    task automatic test_write_x0();
        we = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF; step();
        wr_addr = 0; wr_data = 32'h1234_5678; step();
        idle(); rs_addr = {AW'(0), AW'(5)}; #1;
        checks += 2;
        if (rd_byp !== 64'h0000_0000_DEAD_BEEF) begin
            errors++; $display("FAIL write_x0_byp got %h want 00000000deadbeef", rd_byp);
        end
        if (rd_nob !== 64'h0000_0000_DEAD_BEEF) begin
            errors++; $display("FAIL write_x0_nob got %h want 00000000deadbeef", rd_nob);
        end
    endtask

    task automatic test_bypass();
        we = 1; wr_addr = 7; wr_data = 32'hA5A5_A5A5; rs_addr = {AW'(0), AW'(7)}; #1;
        checks += 2;
        if (rd_byp[31:0] !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL bypass_fwd got %h want a5a5a5a5", rd_byp[31:0]);
        end
        if (rd_nob[31:0] !== 32'h0) begin
            errors++; $display("FAIL nobypass_old got %h want 00000000", rd_nob[31:0]);
        end
        step(); idle(); #1;
        checks++;
        if (rd_nob[31:0] !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL nobypass_after got %h want a5a5a5a5", rd_nob[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        issue_en = 1; issue_addr = 9; step();
        idle(); rs_addr = {AW'(0), AW'(9)}; #1;
        checks++;
        if (bz_byp[0] !== 1'b1 || bz_nob[0] !== 1'b1) begin
            errors++; $display("FAIL sb_issue got %b/%b want 1/1", bz_byp[0], bz_nob[0]);
        end
        we = 1; wr_addr = 9; wr_data = 32'h11; #1;
        checks++;
        if (bz_byp[0] !== 1'b0 || bz_nob[0] !== 1'b1 || rd_byp[31:0] !== 32'h11) begin
            errors++;
            $display("FAIL sb_retire got busy %b/%b data %h want 0/1 data 00000011", bz_byp[0], bz_nob[0], rd_byp[31:0]);
        end
        step(); idle(); #1;
        checks++;
        if (bz_byp[0] !== 1'b0 || bz_nob[0] !== 1'b0 || rd_byp[31:0] !== 32'h11 || rd_nob[31:0] !== 32'h11) begin
            errors++;
            $display("FAIL sb_after got busy %b/%b data %h/%h want 0/0 11/11", bz_byp[0], bz_nob[0], rd_byp[31:0], rd_nob[31:0]);
        end
    endtask

    task automatic test_simultaneous();
        issue_en = 1; issue_addr = 4; we = 1; wr_addr = 4; wr_data = 32'h22; step();
        idle(); rs_addr = {AW'(4), AW'(4)}; #1;
        checks++;
        if (rd_byp !== {32'h22, 32'h22} || bz_byp !== 2'b11 || bz_nob !== 2'b11) begin
            errors++;
            $display("FAIL simul_same got %h busy %b/%b want 0000002200000022 busy 11/11", rd_byp, bz_byp, bz_nob);
        end
        issue_en = 1; issue_addr = 0; step();
        idle(); rs_addr = {AW'(0), AW'(0)}; #1;
        checks++;
        if (rd_byp !== 64'h0 || bz_byp !== 2'b00 || bz_nob !== 2'b00) begin
            errors++; $display("FAIL simul_x0 got %h busy %b/%b want 0 busy 00/00", rd_byp, bz_byp, bz_nob);
        end
    endtask

    task automatic test_reset_mid();
        we = 1; wr_addr = 3; wr_data = 32'h33; step();
        wr_addr = 9; wr_data = 32'h99; step();
        idle(); issue_en = 1; issue_addr = 9; step();
        rst = 1; we = 1; wr_addr = 3; wr_data = 32'h77; issue_en = 1; issue_addr = 3; step();
        rst = 0; idle();
        for (int k = 0; k < NREGS; k++) begin
            rs_addr = {AW'((k + 1) % NREGS), AW'(k)};
            #1;
            checks++;
            if (rd_byp[31:0] !== ((k == 2) ? SPV : 32'h0) || bz_byp[0] !== 1'b0 ||
                rd_nob[31:0] !== ((k == 2) ? SPV : 32'h0) || bz_nob[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid addr%0d got %h/%h busy %b/%b", k, rd_byp[31:0], rd_nob[31:0], bz_byp[0], bz_nob[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 39) == 0);
            we         = $urandom_range(0, 1);
            issue_en   = $urandom_range(0, 1);
            wr_addr    = AW'($urandom_range(0, 7));
            issue_addr = AW'($urandom_range(0, 7));
            wr_data    = $urandom;
            rs_addr    = {AW'($urandom_range(0, 7)), AW'((n % 4 == 0) ? int'(wr_addr) : $urandom_range(0, 31))};
            #1;
            for (int p = 0; p < NRD; p++) begin
                int a;
                a = int'(rs_addr[p*AW +: AW]);
                checks += 2;
                if ({bz_byp[p], rd_byp[p*32 +: 32]} !== exp_rd(a, 1)) begin
                    errors++;
                    $display("FAIL rand_byp cyc%0d port%0d addr%0d got %h want %h", n, p, a,
                             {bz_byp[p], rd_byp[p*32 +: 32]}, exp_rd(a, 1));
                end
                if ({bz_nob[p], rd_nob[p*32 +: 32]} !== exp_rd(a, 0)) begin
                    errors++;
                    $display("FAIL rand_nob cyc%0d port%0d addr%0d got %h want %h", n, p, a,
                             {bz_nob[p], rd_nob[p*32 +: 32]}, exp_rd(a, 0));
                end
            end
            step();
        end
        rst = 0; idle();
    endtask

    initial begin
        rst = 1; rs_addr = '0;
        idle();
        test_reset();
        test_write_x0();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
